// File: rtl/day10_sched_pkg.sv
// Shared types and helpers for the day-10 machine scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package day10_sched_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ_READ  = 3'd1,
    WAIT_READ = 3'd2,
    DISPATCH  = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } sched_state_t;

  // Upper bounds the summing helper is sized for
  localparam int MAX_LANES   = 16;
  localparam int MAX_PRESS_W = 32;
  localparam int SUM_W       = MAX_PRESS_W + 4;

  // Lane index width, never narrower than one bit
  function automatic int lane_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Sum of the zero-extended results of every lane whose done bit is set
  function automatic logic [SUM_W-1:0] sum_done_results(
    input logic [MAX_LANES-1:0]             done_mask,
    input logic [MAX_LANES*MAX_PRESS_W-1:0] results
  );
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (done_mask[i]) begin
        acc = acc + SUM_W'(results[i*MAX_PRESS_W +: MAX_PRESS_W]);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/day10_lane_picker.sv
// Round-robin first-free lane search starting at the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; found_o=0 when every lane is busy.
module day10_lane_picker #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
) (
  input  logic [NUM_LANES-1:0] busy_mask_i,
  input  logic [LANE_W-1:0]    ptr_i,
  output logic                 found_o,
  output logic [LANE_W-1:0]    lane_idx_o
);

  // Walk candidates farthest-first so the nearest free lane from ptr_i wins
  always_comb begin
    int cand;
    found_o    = 1'b0;
    lane_idx_o = '0;
    cand       = 0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      cand = (int'(ptr_i) + i) % NUM_LANES;
      for (int j = 0; j < NUM_LANES; j++) begin
        if (j == cand && !busy_mask_i[j]) begin
          found_o    = 1'b1;
          lane_idx_o = LANE_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/day10_machine_scheduler.sv
// Reads machines one at a time, dispatches each round-robin to a free solver lane, sums results, drains, flags done.
// Latency: reader_ready to lane_start is 1 cycle when a lane is free; a lane freed in cycle t is reusable at t+1.
// Backpressure: holds in DISPATCH (reader idle, data stable) while all lanes are busy. Optional DAY10_SCHED_STATS_EN adds stall/run counters.
module day10_machine_scheduler
  import day10_sched_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int PRESS_W       = 8,
  parameter int TOTAL_W       = 32,
  parameter int MACHINE_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         go,
  output logic                         reader_start,
  input  logic                         reader_ready,
  input  logic                         end_of_input,
  output logic [NUM_LANES-1:0]         lane_start,
  input  logic [NUM_LANES-1:0]         lane_done,
  input  logic [NUM_LANES*PRESS_W-1:0] lane_result,
  output logic [TOTAL_W-1:0]           total,
  output logic [MACHINE_CNT_W-1:0]     machines,
  output logic                         busy,
  output logic                         done
`ifdef DAY10_SCHED_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  run_cycles
`endif
);

  localparam int LANE_W = lane_w(NUM_LANES);

  sched_state_t               state_q;
  logic                       eoi_seen_q;
  logic                       reader_start_q;
  logic                       busy_q;
  logic                       done_q;
  logic [NUM_LANES-1:0]       lane_busy_q, lane_busy_d;
  logic [LANE_W-1:0]          rr_q, rr_d;
  logic [TOTAL_W-1:0]         total_q, total_d;
  logic [MACHINE_CNT_W-1:0]   machines_q, machines_d;

  logic                       lane_found;
  logic [LANE_W-1:0]          lane_idx;
  logic                       go_accept;
  logic                       dispatch;
  logic [NUM_LANES-1:0]       eff_done;
  logic [MAX_LANES-1:0]       done_ext;
  logic [MAX_LANES*MAX_PRESS_W-1:0] res_ext;
  logic [SUM_W-1:0]           done_sum;

  day10_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_picker (
    .busy_mask_i (lane_busy_q),
    .ptr_i       (rr_q),
    .found_o     (lane_found),
    .lane_idx_o  (lane_idx)
  );

  assign go_accept  = go && (state_q == IDLE || state_q == DONE);
  assign dispatch   = (state_q == DISPATCH) && lane_found;
  assign lane_start = dispatch ? (NUM_LANES'(1) << lane_idx) : '0;

  // Completions only count on lanes we actually launched; sum them all at once
  always_comb begin
    eff_done = lane_done & lane_busy_q;
    done_ext = '0;
    res_ext  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      done_ext[i]                          = eff_done[i];
      res_ext[i*MAX_PRESS_W +: MAX_PRESS_W] = MAX_PRESS_W'(lane_result[i*PRESS_W +: PRESS_W]);
    end
    done_sum = sum_done_results(done_ext, res_ext);
  end

  // Next-state for the lane mask, pointer, running total and dispatch count
  always_comb begin
    lane_busy_d = (lane_busy_q & ~eff_done) | lane_start;
    rr_d        = rr_q;
    if (dispatch) begin
      rr_d = (lane_idx == LANE_W'(NUM_LANES - 1)) ? '0 : lane_idx + LANE_W'(1);
    end
    total_d    = go_accept ? '0 : total_q + TOTAL_W'(done_sum);
    machines_d = machines_q;
    if (go_accept) begin
      machines_d = '0;
    end else if (dispatch && machines_q != '1) begin
      machines_d = machines_q + MACHINE_CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_busy_q <= '0;
      rr_q        <= '0;
      total_q     <= '0;
      machines_q  <= '0;
    end else begin
      lane_busy_q <= lane_busy_d;
      rr_q        <= rr_d;
      total_q     <= total_d;
      machines_q  <= machines_d;
    end
  end

  // Control FSM; reader_start/busy/done are registered alongside the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      eoi_seen_q     <= 1'b0;
      reader_start_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      reader_start_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (go) begin
            state_q        <= REQ_READ;
            eoi_seen_q     <= 1'b0;
            reader_start_q <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
          end
        end
        REQ_READ: state_q <= WAIT_READ;
        WAIT_READ: begin
          if (reader_ready) begin
            eoi_seen_q <= end_of_input;
            state_q    <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (lane_found) begin
            if (eoi_seen_q) begin
              state_q <= DRAIN;
            end else begin
              state_q        <= REQ_READ;
              reader_start_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (lane_busy_q == '0 && eff_done == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reader_start = reader_start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign total        = total_q;
  assign machines     = machines_q;

`ifdef DAY10_SCHED_STATS_EN
  logic [31:0] stall_q, run_q;

  // Saturating stall and run-length counters, cleared when a run starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      run_q   <= '0;
    end else if (go_accept) begin
      stall_q <= '0;
      run_q   <= '0;
    end else begin
      if (state_q == DISPATCH && !lane_found && stall_q != '1) begin
        stall_q <= stall_q + 32'd1;
      end
      if (busy_q && run_q != '1) begin
        run_q <= run_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign run_cycles   = run_q;
`endif

endmodule

// File: tb/tb_day10_machine_scheduler.sv
// Directed scoreboard bench: reader and lane models drive the scheduler, a negedge monitor checks lane_start and done.
// Latency: expectations carry the exact cycle (relative to go) of each lane_start and of done.
// Backpressure: lane latencies are chosen so that all-lanes-busy stalls occur.
module tb_day10_machine_scheduler;

  localparam int NL = 2;
  localparam int PW = 8;
  localparam int TW = 32;
  localparam int MW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             go = 1'b0;
  logic             reader_start;
  logic             reader_ready = 1'b0;
  logic             end_of_input = 1'b0;
  logic [NL-1:0]    lane_start;
  logic [NL-1:0]    lane_done = '0;
  logic [NL*PW-1:0] lane_result = '0;
  logic [TW-1:0]    total;
  logic [MW-1:0]    machines;
  logic             busy;
  logic             done;
`ifdef DAY10_SCHED_STATS_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      run_cycles;
`endif

  day10_machine_scheduler #(
    .NUM_LANES     (NL),
    .PRESS_W       (PW),
    .TOTAL_W       (TW),
    .MACHINE_CNT_W (MW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .reader_start (reader_start),
    .reader_ready (reader_ready),
    .end_of_input (end_of_input),
    .lane_start   (lane_start),
    .lane_done    (lane_done),
    .lane_result  (lane_result),
    .total        (total),
    .machines     (machines),
    .busy         (busy),
    .done         (done)
`ifdef DAY10_SCHED_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .run_cycles   (run_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Test configuration, written only by the stimulus process
  int              n_mach = 1;
  bit              eoi_early = 1'b0;
  int              lat_tab[8];
  int              res_tab[8];
  int              inj_req = 0;
  logic [NL-1:0]   inj_mask = '0;
  logic [NL*PW-1:0] inj_res = '0;

  typedef struct {
    int lane;
    int cyc;
    int tot;
  } lane_exp_t;

  typedef struct {
    int tot;
    int mach;
    int rs;
    int cyc;
    int stall;
    int run;
  } done_exp_t;

  lane_exp_t lq[$];
  done_exp_t dq[$];

  task automatic push_lane(input int l, input int c, input int t);
    lane_exp_t e;
    e.lane = l; e.cyc = c; e.tot = t;
    lq.push_back(e);
  endtask

  task automatic push_done(input int t, input int m, input int rs, input int c, input int st, input int rn);
    done_exp_t e;
    e.tot = t; e.mach = m; e.rs = rs; e.cyc = c; e.stall = st; e.run = rn;
    dq.push_back(e);
  endtask

  task automatic set_m(input int i, input int lat, input int res);
    lat_tab[i] = lat;
    res_tab[i] = res;
  endtask

  // Reader and lane models, updated 2 time units after each rising edge
  initial begin
    int lt[NL];
    int lr[NL];
    int rd_timer;
    int rd_idx;
    int disp_idx;
    int inj_ack;
    rd_timer = 0; rd_idx = 0; disp_idx = 0; inj_ack = 0;
    for (int i = 0; i < NL; i++) begin lt[i] = 0; lr[i] = 0; end
    forever begin
      @(posedge clk);
      #2;
      reader_ready = 1'b0;
      lane_done    = '0;
      if (!rst_n) begin
        rd_timer = 0; rd_idx = 0; disp_idx = 0;
        end_of_input = 1'b0;
        for (int i = 0; i < NL; i++) lt[i] = 0;
      end else begin
        if (go) begin
          rd_idx = 0; disp_idx = 0;
          end_of_input = eoi_early;
        end
        if (rd_timer > 0) begin
          rd_timer--;
          if (rd_timer == 0) begin
            reader_ready = 1'b1;
            rd_idx++;
            if (rd_idx >= n_mach) end_of_input = 1'b1;
          end
        end
        if (reader_start) rd_timer = 1;
        for (int i = 0; i < NL; i++) begin
          if (lt[i] > 0) begin
            lt[i]--;
            if (lt[i] == 0) begin
              lane_done[i] = 1'b1;
              lane_result[i*PW +: PW] = PW'(lr[i]);
            end
          end
          if (lane_start[i]) begin
            lt[i] = lat_tab[disp_idx];
            lr[i] = res_tab[disp_idx];
            disp_idx++;
          end
        end
        if (inj_req != inj_ack) begin
          lane_done   = lane_done | inj_mask;
          lane_result = inj_res;
          inj_ack     = inj_req;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT launches a lane or finishes a run
  initial begin
    int base;
    int rs_cnt;
    int idx;
    logic done_prev;
    lane_exp_t le;
    done_exp_t de;
    base = 0; rs_cnt = 0; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (go) begin
        base   = cyc;
        rs_cnt = 0;
      end
      if (reader_start) rs_cnt++;
      if (lane_start != '0) begin
        if (lq.size() == 0) begin
          chk("lane_start_unexpected", lane_start, 0);
        end else begin
          le  = lq.pop_front();
          idx = -1;
          for (int i = 0; i < NL; i++) if (lane_start[i]) idx = i;
          chk("lane_onehot", $countones(lane_start), 1);
          chk("lane_idx", idx, le.lane);
          chk("lane_cycle", cyc - base, le.cyc);
          chk("total_at_lane_start", total, le.tot);
        end
      end
      if (done && !done_prev) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          de = dq.pop_front();
          chk("done_total", total, de.tot);
          chk("done_machines", machines, de.mach);
          chk("done_reader_starts", rs_cnt, de.rs);
          chk("done_cycle", cyc - base, de.cyc);
          chk("done_busy", busy, 0);
`ifdef DAY10_SCHED_STATS_EN
          chk("stall_cycles", stall_cycles, de.stall);
          chk("run_cycles", run_cycles, de.run);
`endif
        end
      end
      done_prev = done;
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_total"}, total, 0);
    chk({tag, "_machines"}, machines, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_reader_start"}, reader_start, 0);
    chk({tag, "_lane_start"}, lane_start, 0);
  endtask

  task automatic pulse_go();
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // Start a run and wait (bounded) for done, then confirm every expected launch was seen
  task automatic run_and_wait(input string tag, input int max_cyc);
    bit got;
    got = 1'b0;
    pulse_go();
    for (int k = 0; k < max_cyc; k++) begin
      if (done) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, got, 1);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_lane_exp_left"}, lq.size(), 0);
    chk({tag, "_done_exp_left"}, dq.size(), 0);
    lq.delete();
    dq.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three machines on two lanes: third waits for lane0 (done at 13)
    n_mach = 3; eoi_early = 1'b0;
    set_m(0, 10, 3); set_m(1, 10, 2); set_m(2, 10, 5);
    push_lane(0, 3, 0); push_lane(1, 6, 0); push_lane(0, 14, 3);
    push_done(10, 3, 3, 26, 5, 25);
    run_and_wait("basic", 200);

    // Pointer now at lane1; lane1 finishes (result 4) at 15, relaunched at 16
    n_mach = 3; eoi_early = 1'b0;
    set_m(0, 12, 4); set_m(1, 30, 6); set_m(2, 10, 5);
    push_lane(1, 3, 0); push_lane(0, 6, 0); push_lane(1, 16, 4);
    push_done(15, 3, 3, 38, 7, 37);
    run_and_wait("stall", 200);

    // Both lanes complete in cycle 16 with 7 and 9
    n_mach = 2; eoi_early = 1'b0;
    set_m(0, 13, 7); set_m(1, 10, 9);
    push_lane(0, 3, 0); push_lane(1, 6, 0);
    push_done(16, 2, 2, 18, 0, 17);
    run_and_wait("same_cycle", 200);

    // end_of_input already high on the first read
    n_mach = 1; eoi_early = 1'b1;
    set_m(0, 10, 2);
    push_lane(0, 3, 0);
    push_done(2, 1, 1, 15, 0, 14);
    run_and_wait("eoi_first", 200);

    // Completions on idle lanes while in DONE must be ignored
    inj_mask = 2'b11;
    inj_res  = {8'd60, 8'd50};
    inj_req++;
    repeat (3) @(posedge clk);
    #1;
    chk("spurious_total", total, 2);
    chk("spurious_done", done, 1);
    chk("spurious_busy", busy, 0);

    // Reset while stalled in DISPATCH with both lanes busy
    n_mach = 5; eoi_early = 1'b0;
    set_m(0, 4, 11); set_m(1, 50, 1); set_m(2, 50, 1); set_m(3, 50, 1); set_m(4, 50, 1);
    push_lane(1, 3, 0); push_lane(0, 6, 0); push_lane(1, 9, 11);
    pulse_go();
    repeat (13) @(posedge clk);
    #1;
    chk("midrun_busy", busy, 1);
    chk("midrun_machines", machines, 3);
    chk("midrun_total", total, 11);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrun_reset");
    chk("midrun_lane_exp_left", lq.size(), 0);
    lq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh run after reset: pointer back at lane0, total restarts at 0
    n_mach = 1; eoi_early = 1'b0;
    set_m(0, 5, 9);
    push_lane(0, 3, 0);
    push_done(9, 1, 1, 10, 0, 9);
    run_and_wait("after_reset", 200);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
